// File: rtl/popcount_ternary_acc.sv
// Streaming ternary popcount accumulator: sums popcount(pos)-popcount(neg) over beats
// and classifies the neuron total against two signed thresholds on the closing beat.
module popcount_ternary_acc #(
    parameter int W         = 7,
    parameter int MAX_BEATS = 16,
    parameter int DROP      = 0,
    localparam int CW       = $clog2(MAX_BEATS + 1),
    localparam int SW       = $clog2(W * MAX_BEATS + 1) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_pos,
    input  logic [W-1:0]         in_neg,
    input  logic                 in_last,
    input  logic signed [SW-1:0] thr_hi,
    input  logic signed [SW-1:0] thr_lo,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [SW-1:0] out_sum,
    output logic [1:0]           out_tern,
    output logic                 out_ovf
);

    localparam int PCW = $clog2(W + 1);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t                r_state;
    logic signed [SW-1:0]  r_acc;
    logic [CW-1:0]         r_beat_cnt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic signed [SW-1:0]  r_out_sum;
    logic [1:0]            r_out_tern;
    logic                  r_out_ovf;

    logic [W-1:0]          w_p;
    logic [W-1:0]          w_n;
    logic [PCW-1:0]        w_pc_p;
    logic [PCW-1:0]        w_pc_n;
    logic signed [SW-1:0]  w_d;
    logic signed [SW-1:0]  w_sum;
    logic                  w_hs;
    logic                  w_last;

    function automatic logic [PCW-1:0] popcount(input logic [W-1:0] v);
        logic [PCW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + PCW'(v[i]);
        end
        return cnt;
    endfunction

    function automatic logic [PCW-1:0] truncate_lsbs(input logic [PCW-1:0] v);
        logic [PCW-1:0] mask;
        mask = '1;
        mask = mask << DROP;
        return v & mask;
    endfunction

    // High threshold wins when both tests hold (e.g. thr_lo >= thr_hi).
    function automatic logic [1:0] classify(input logic signed [SW-1:0] s,
                                            input logic signed [SW-1:0] hi,
                                            input logic signed [SW-1:0] lo);
        if (s >= hi) begin
            return 2'b01;
        end else if (s <= lo) begin
            return 2'b11;
        end
        return 2'b00;
    endfunction

    // Bits asserted on both rails cancel before counting.
    assign w_p    = in_pos & ~in_neg;
    assign w_n    = in_neg & ~in_pos;
    assign w_pc_p = truncate_lsbs(popcount(w_p));
    assign w_pc_n = truncate_lsbs(popcount(w_n));
    assign w_d    = $signed(SW'(w_pc_p)) - $signed(SW'(w_pc_n));
    assign w_sum  = r_acc + w_d;
    assign w_hs   = in_valid & r_in_ready;
    assign w_last = in_last | (r_beat_cnt == CW'(MAX_BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACC;
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_tern  <= 2'b00;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_out_sum   <= w_sum;
                            r_out_ovf   <= ~in_last;
                            r_out_tern  <= classify(w_sum, thr_hi, thr_lo);
                            r_acc       <= '0;
                            r_beat_cnt  <= '0;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_OUT;
                        end else begin
                            r_acc      <= w_sum;
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    // No bypass: input side reopens only on the edge after consumption.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ACC;
                    end
                end
                default: begin
                    r_state <= ST_ACC;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_tern  = r_out_tern;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_popcount_ternary_acc.sv
// Bench for popcount_ternary_acc: three instances (exact, MAX_BEATS=4, DROP=1) checked
// against a neuron-level arithmetic model with directed and randomized stimulus.
module tb_popcount_ternary_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [2:0]        vld;
    logic [2:0]        ordy;
    logic [6:0]        pos;
    logic [6:0]        neg;
    logic              last;
    logic signed [7:0] thr_hi;
    logic signed [7:0] thr_lo;
    logic signed [5:0] thr_hi6;
    logic signed [5:0] thr_lo6;

    wire [2:0]         rdy;
    wire [2:0]         ov;
    wire [2:0]         ovf;
    wire [1:0]         tern0, tern1, tern2;
    wire signed [7:0]  sum0, sum2;
    wire signed [5:0]  sum1;

    assign thr_hi6 = thr_hi[5:0];
    assign thr_lo6 = thr_lo[5:0];

    popcount_ternary_acc u_exact (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_pos(pos), .in_neg(neg), .in_last(last), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(sum0), .out_tern(tern0), .out_ovf(ovf[0])
    );

    popcount_ternary_acc #(.MAX_BEATS(4)) u_ovf (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_pos(pos), .in_neg(neg), .in_last(last), .thr_hi(thr_hi6), .thr_lo(thr_lo6),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(sum1), .out_tern(tern1), .out_ovf(ovf[1])
    );

    popcount_ternary_acc #(.DROP(1)) u_drop (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]),
        .in_pos(pos), .in_neg(neg), .in_last(last), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(sum2), .out_tern(tern2), .out_ovf(ovf[2])
    );

    int n_cmp = 0;
    int n_fail = 0;
    int m_acc, m_cnt, e_sum, e_thi, e_tlo;
    bit m_done, e_ovf;

    function automatic int mb(input int sel);
        return (sel == 1) ? 4 : 16;
    endfunction

    function automatic int get_sum(input int sel);
        case (sel)
            0: return int'(sum0);
            1: return int'(sum1);
            default: return int'(sum2);
        endcase
    endfunction

    function automatic logic [1:0] get_tern(input int sel);
        case (sel)
            0: return tern0;
            1: return tern1;
            default: return tern2;
        endcase
    endfunction

    function automatic int beat_val(input int sel, input logic [6:0] p, input logic [6:0] n);
        int a, b, dr;
        a = $countones(p & ~n);
        b = $countones(n & ~p);
        dr = (sel == 2) ? 1 : 0;
        a = (a >> dr) << dr;
        b = (b >> dr) << dr;
        return a - b;
    endfunction

    function automatic logic [1:0] exp_tern();
        if (e_sum >= e_thi) return 2'b01;
        if (e_sum <= e_tlo) return 2'b11;
        return 2'b00;
    endfunction

    task automatic set_thr(input int hi, input int lo);
        thr_hi = 8'(hi);
        thr_lo = 8'(lo);
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
        m_done = 0;
    endtask

    task automatic beat(input int sel, input logic [6:0] p, input logic [6:0] n, input logic l);
        int cyc;
        cyc = 0;
        pos = p;
        neg = n;
        last = l;
        vld[sel] = 1'b1;
        while (rdy[sel] !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 20) begin
            n_cmp++; n_fail++;
            $display("FAIL handshake_timeout sel=%0d in_ready=%b required 1", sel, rdy[sel]);
        end
        @(posedge clk); #1;
        vld[sel] = 1'b0;
        m_acc += beat_val(sel, p, n);
        m_cnt++;
        if (l || m_cnt == mb(sel)) begin
            m_done = 1;
            e_sum = m_acc;
            e_ovf = !l;
            e_thi = int'(thr_hi);
            e_tlo = int'(thr_lo);
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic check_out(input int sel, input string tag);
        n_cmp++;
        if (ov[sel] !== 1'b1) begin
            n_fail++; $display("FAIL %s_valid sel=%0d got %b required 1", tag, sel, ov[sel]);
        end
        n_cmp++;
        if (get_sum(sel) !== e_sum) begin
            n_fail++; $display("FAIL %s_sum sel=%0d got %0d required %0d", tag, sel, get_sum(sel), e_sum);
        end
        n_cmp++;
        if (get_tern(sel) !== exp_tern()) begin
            n_fail++; $display("FAIL %s_tern sel=%0d got %b required %b", tag, sel, get_tern(sel), exp_tern());
        end
        n_cmp++;
        if (ovf[sel] !== e_ovf) begin
            n_fail++; $display("FAIL %s_ovf sel=%0d got %b required %b", tag, sel, ovf[sel], e_ovf);
        end
        n_cmp++;
        if (rdy[sel] !== 1'b0) begin
            n_fail++; $display("FAIL %s_in_ready sel=%0d got %b required 0", tag, sel, rdy[sel]);
        end
    endtask

    // Holds the result for 'hold' cycles while throwing ignored beats and new thresholds at it.
    task automatic consume(input int sel, input int hold, input string tag);
        for (int i = 0; i < hold; i++) begin
            vld[sel] = 1'b1;
            pos = 7'($urandom);
            neg = 7'($urandom);
            last = 1'($urandom);
            set_thr(int'($urandom_range(0, 30)) - 15, int'($urandom_range(0, 30)) - 15);
            @(posedge clk); #1;
            check_out(sel, tag);
        end
        vld[sel] = 1'b0;
        ordy[sel] = 1'b1;
        @(posedge clk); #1;
        ordy[sel] = 1'b0;
        n_cmp++;
        if (ov[sel] !== 1'b0) begin
            n_fail++; $display("FAIL %s_consume_valid sel=%0d got %b required 0", tag, sel, ov[sel]);
        end
        n_cmp++;
        if (rdy[sel] !== 1'b1) begin
            n_fail++; $display("FAIL %s_consume_ready sel=%0d got %b required 1", tag, sel, rdy[sel]);
        end
        m_done = 0;
    endtask

    task automatic check_idle(input int sel, input string tag);
        n_cmp++;
        if (rdy[sel] !== 1'b1 || ov[sel] !== 1'b0) begin
            n_fail++; $display("FAIL %s_ctrl sel=%0d got ready=%b valid=%b required 1/0", tag, sel, rdy[sel], ov[sel]);
        end
        n_cmp++;
        if (get_sum(sel) !== 0 || get_tern(sel) !== 2'b00 || ovf[sel] !== 1'b0) begin
            n_fail++; $display("FAIL %s_outs sel=%0d got sum=%0d tern=%b ovf=%b required 0/00/0",
                               tag, sel, get_sum(sel), get_tern(sel), ovf[sel]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vld = '0; ordy = '0; pos = '0; neg = '0; last = 1'b0;
        set_thr(0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) check_idle(s, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_exact();
        set_thr(4, -4);
        beat(0, 7'h7F, 7'h00, 1'b1);
        check_out(0, "exact");
        consume(0, 0, "exact");
    endtask

    task automatic test_cancel();
        set_thr(2, -2);
        beat(0, 7'b0001111, 7'b0000111, 1'b1);
        check_out(0, "cancel");
        consume(0, 1, "cancel");
    endtask

    task automatic test_multi_beat();
        set_thr(4, -3);
        beat(0, 7'b0000111, 7'b0000000, 1'b0);
        beat(0, 7'b0000000, 7'b1111111, 1'b0);
        beat(0, 7'b0000011, 7'b0000100, 1'b1);
        check_out(0, "multi");
        consume(0, 0, "multi");
    endtask

    task automatic test_overflow();
        set_thr(3, -3);
        for (int i = 0; i < 4; i++) beat(1, 7'(1 << (i + 2)), 7'h00, 1'b0);
        check_out(1, "ovf");
        consume(1, 3, "ovf_stall");
    endtask

    task automatic test_drop();
        set_thr(4, -4);
        beat(2, 7'h7F, 7'b0000111, 1'b1);
        check_out(2, "drop_a");
        consume(2, 0, "drop_a");
        set_thr(4, -4);
        beat(2, 7'b0011111, 7'h00, 1'b1);
        check_out(2, "drop_b");
        consume(2, 0, "drop_b");
        set_thr(3, -3);
        beat(2, 7'b0000111, 7'h00, 1'b1);
        check_out(2, "drop_c");
        consume(2, 0, "drop_c");
    endtask

    task automatic test_backpressure_reset();
        set_thr(5, -5);
        beat(0, 7'($urandom), 7'($urandom), 1'b0);
        beat(0, 7'($urandom), 7'($urandom), 1'b1);
        check_out(0, "bp");
        consume(0, 5, "bp");
        beat(0, 7'h7F, 7'h00, 1'b0);
        beat(0, 7'h3F, 7'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle(0, "midreset");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_thr(1, -1);
        beat(0, 7'b0000001, 7'b0000110, 1'b0);
        beat(0, 7'b0000000, 7'b0000000, 1'b1);
        check_out(0, "after_reset");
        consume(0, 0, "after_reset");
    endtask

    task automatic rand_neuron(input int sel);
        int n;
        bit nolast;
        nolast = ($urandom_range(0, 3) == 0);
        n = nolast ? mb(sel) : int'($urandom_range(1, mb(sel)));
        set_thr(int'($urandom_range(0, 30)) - 15, int'($urandom_range(0, 30)) - 15);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pos = 7'($urandom);
                neg = 7'($urandom);
                @(posedge clk); #1;
            end
            beat(sel, 7'($urandom), 7'($urandom), !nolast && (i == n - 1));
        end
        check_out(sel, "rand");
        consume(sel, int'($urandom_range(0, 2)), "rand");
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            for (int s = 0; s < 3; s++) rand_neuron(s);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_exact();
        test_cancel();
        test_multi_beat();
        test_overflow();
        test_drop();
        test_backpressure_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
